// File: rtl/dac_spi_serializer.sv
// Unpacks 3-byte DAC engine bursts into two 12-bit codes, shifts them out as
// 16-bit SPI frames to a dual serial DAC, and issues LDAC pulses on request.
module dac_spi_serializer #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP        = 2,
  parameter int unsigned LDAC_WIDTH = 2,
  parameter logic        BUF        = 1'b1
) (
  input  logic       ti_clk,
  input  logic       rst,
  input  logic [7:0] dac_data,
  input  logic       dac_data_en,
  input  logic       dac_set,
  output logic       sclk,
  output logic       sync_n,
  output logic       sdin,
  output logic       ldac_n,
  output logic       busy,
  output logic       err_len,
  output logic       err_ovf
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 24;
  localparam int unsigned CODE_W  = 12;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned HALF_W  = 5;
  localparam int unsigned NB_W    = 3;

  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0]  LDAC_LAST = CNT_W'(LDAC_WIDTH - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_W - 1);
  localparam logic [NB_W-1:0]   NB_WORD   = NB_W'(3);
  localparam logic [NB_W-1:0]   NB_SAT    = NB_W'(4);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT_A = 3'd1,
    S_GAP_A   = 3'd2,
    S_SHIFT_B = 3'd3,
    S_GAP_B   = 3'd4,
    S_LDAC    = 3'd5
  } state_t;

  function automatic logic [FRAME_W-1:0] frame_a(input logic [WORD_W-1:0] w);
    return {1'b0, BUF, 2'b00, w[WORD_W-1:CODE_W]};
  endfunction

  function automatic logic [FRAME_W-1:0] frame_b(input logic [WORD_W-1:0] w);
    return {1'b1, BUF, 2'b00, w[CODE_W-1:0]};
  endfunction

  state_t              r_state;
  logic                r_en_d;
  logic                r_set_d;
  logic [WORD_W-1:0]   r_collect;
  logic [NB_W-1:0]     r_nbytes;
  logic [WORD_W-1:0]   r_word;
  logic [FRAME_W-1:0]  r_frame;
  logic [WORD_W-1:0]   r_pend;
  logic                r_pend_vld;
  logic                r_ldac_req;
  logic [CNT_W-1:0]    r_div;
  logic [HALF_W-1:0]   r_half;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sclk;
  logic                r_sync_n;
  logic                r_sdin;
  logic                r_ldac_n;
  logic                r_busy;
  logic                r_err_len;
  logic                r_err_ovf;

  logic                w_burst_end;
  logic                w_word_vld;
  logic                w_set_rise;
  logic                w_req_any;
  logic                w_div_last;
  logic                w_gap_last;
  logic                w_ldac_last;
  logic                w_load_pt;
  logic                w_take;
  logic                w_ldac_enter;
  logic                w_shifting;
  logic [WORD_W-1:0]   w_next_word;

  // Burst evaluation happens on the first cycle with the enable low again.
  assign w_burst_end = r_en_d & ~dac_data_en;
  assign w_word_vld  = w_burst_end & (r_nbytes == NB_WORD);
  assign w_set_rise  = dac_set & ~r_set_d;
  assign w_req_any   = r_ldac_req | w_set_rise;

  assign w_div_last  = (r_div == DIV_LAST);
  assign w_gap_last  = (r_cnt == GAP_LAST);
  assign w_ldac_last = (r_cnt == LDAC_LAST);
  assign w_shifting  = (r_state == S_SHIFT_A) | (r_state == S_SHIFT_B);

  // Points where the shifter can accept a new word; a pending word is older
  // than one arriving this cycle, so it goes first.
  assign w_load_pt   = (r_state == S_IDLE)
                     | ((r_state == S_GAP_B) & w_gap_last)
                     | ((r_state == S_LDAC) & w_ldac_last);
  assign w_take      = w_load_pt & (r_pend_vld | w_word_vld);
  assign w_next_word = r_pend_vld ? r_pend : r_collect;

  assign w_ldac_enter = ~w_take & w_req_any &
                        ((r_state == S_IDLE) | ((r_state == S_GAP_B) & w_gap_last));

  // Byte collector and edge detectors.
  always_ff @(posedge ti_clk) begin
    if (rst) begin
      r_en_d    <= 1'b0;
      r_set_d   <= 1'b0;
      r_collect <= '0;
      r_nbytes  <= '0;
      r_err_len <= 1'b0;
    end else begin
      r_en_d  <= dac_data_en;
      r_set_d <= dac_set;
      if (dac_data_en) begin
        r_collect <= {r_collect[WORD_W-BYTE_W-1:0], dac_data};
        if (r_nbytes != NB_SAT) r_nbytes <= r_nbytes + NB_W'(1);
      end else if (w_burst_end) begin
        r_nbytes <= '0;
        if (r_nbytes != NB_WORD) r_err_len <= 1'b1;
      end
    end
  end

  // Pending slot and LDAC request.
  always_ff @(posedge ti_clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_ldac_req <= 1'b0;
    end else begin
      if (w_take) begin
        if (r_pend_vld && w_word_vld) r_pend <= r_collect;
        else                          r_pend_vld <= 1'b0;
      end else if (w_word_vld) begin
        if (!r_pend_vld) begin
          r_pend     <= r_collect;
          r_pend_vld <= 1'b1;
        end else begin
          r_err_ovf <= 1'b1;
        end
      end
      if (w_ldac_enter)    r_ldac_req <= 1'b0;
      else if (w_set_rise) r_ldac_req <= 1'b1;
    end
  end

  // Frame sequencer.
  always_ff @(posedge ti_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_frame <= '0;
      r_div   <= '0;
      r_half  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_GAP_B, S_LDAC: begin
          if (w_take) begin
            r_state <= S_SHIFT_A;
            r_word  <= w_next_word;
            r_frame <= frame_a(w_next_word);
            r_div   <= '0;
            r_half  <= '0;
          end else if (w_ldac_enter) begin
            r_state <= S_LDAC;
            r_cnt   <= '0;
          end else if (w_load_pt) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SHIFT_A, S_SHIFT_B: begin
          if (w_div_last) begin
            r_div  <= '0;
            r_half <= r_half + HALF_W'(1);
            if (r_half[0]) r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
            if (r_half == HALF_LAST) begin
              r_state <= (r_state == S_SHIFT_A) ? S_GAP_A : S_GAP_B;
              r_cnt   <= '0;
            end
          end else begin
            r_div <= r_div + CNT_W'(1);
          end
        end
        S_GAP_A: begin
          if (w_gap_last) begin
            r_state <= S_SHIFT_B;
            r_frame <= frame_b(r_word);
            r_div   <= '0;
            r_half  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered pin stage, one cycle behind the sequencer.
  always_ff @(posedge ti_clk) begin
    if (rst) begin
      r_sclk   <= 1'b1;
      r_sync_n <= 1'b1;
      r_sdin   <= 1'b0;
      r_ldac_n <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_sclk   <= w_shifting ? ~r_half[0] : 1'b1;
      r_sync_n <= ~w_shifting;
      r_sdin   <= w_shifting & r_frame[FRAME_W-1];
      r_ldac_n <= (r_state != S_LDAC);
      r_busy   <= (r_state != S_IDLE) | r_pend_vld | r_ldac_req;
    end
  end

  assign sclk    = r_sclk;
  assign sync_n  = r_sync_n;
  assign sdin    = r_sdin;
  assign ldac_n  = r_ldac_n;
  assign busy    = r_busy;
  assign err_len = r_err_len;
  assign err_ovf = r_err_ovf;

endmodule
